// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, branch flag and stall/flush outputs of pipe_ctrl.
// PIPE_CTRL_PERF_EN adds the stall_cycles/flush_count performance outputs.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_flag;
    logic [5:0]  stall;
    logic        flush;
    logic        stall_tmo;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, branch_flag,
        input  stall, flush, stall_tmo, stall_cycles, flush_count
    );
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, branch_flag,
        output stall, flush, stall_tmo, stall_cycles, flush_count
    );
`else
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, branch_flag,
        input  stall, flush, stall_tmo
    );
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, branch_flag,
        output stall, flush, stall_tmo
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: priority stall generation, deferred branch flush and sticky stall watchdog.
// PIPE_CTRL_PERF_EN adds stall-cycle and flush counters.
module pipe_ctrl #(
    parameter int TMO_W = 8
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {RUN, FLUSH_PEND} state_t;
    state_t           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic [5:0]       stall;
    logic             stalled, cnt_max, want_flush, flush;
    always_comb begin
        stall = rst              ? 6'b000000 :
                bus.stallreq_mem ? 6'b011111 :
                bus.stallreq_ex  ? 6'b001111 :
                bus.stallreq_id  ? 6'b000111 :
                bus.stallreq_if  ? 6'b000011 : 6'b000000;
    end
    assign stalled = |stall;
    assign cnt_max = &cnt_q;
    // A branch seen while IF/ID is held is remembered once and released when IF/ID moves.
    always_comb begin
        want_flush = (state_q == FLUSH_PEND) || bus.branch_flag;
        flush      = !rst && !stall[1] && want_flush;
        state_d    = (stall[1] && want_flush) ? FLUSH_PEND : RUN;
        cnt_d      = !stalled ? '0 : cnt_max ? cnt_q : cnt_q + 1'b1;
        tmo_d      = tmo_q || (stalled && cnt_max);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end
    assign bus.stall     = stall;
    assign bus.flush     = flush;
    assign bus.stall_tmo = tmo_q;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
    always_comb begin
        stall_cycles_d = stalled ? stall_cycles_q + 32'd1 : stall_cycles_q;
        flush_count_d  = flush ? flush_count_q + 32'd1 : flush_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors feed a scoreboard queue; a negedge monitor pops and compares.
module tb_pipe_ctrl;
    typedef struct {
        int          id;
        logic [5:0]  st;
        logic        fl;
        logic        tmo;
        logic        pchk;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          vec = 0;
    logic        exp_pchk = 1'b0;
    logic [31:0] exp_sc = '0;
    logic [31:0] exp_fc = '0;
    pipe_ctrl_if bus ();
    pipe_ctrl #(.TMO_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic step(input logic r, input logic [3:0] req, input logic br,
                        input logic [5:0] st, input logic fl, input logic tm);
        rst = r;
        {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if} = req;
        bus.branch_flag = br;
        q.push_back('{vec, st, fl, tm, exp_pchk, exp_sc, exp_fc});
        vec++;
        exp_pchk = 1'b0;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.stall !== e.st || bus.flush !== e.fl || bus.stall_tmo !== e.tmo) begin
                errors++;
                $display("FAIL vec%0d: got stall=%b flush=%b tmo=%b, expected stall=%b flush=%b tmo=%b",
                         e.id, bus.stall, bus.flush, bus.stall_tmo, e.st, e.fl, e.tmo);
            end
`ifdef PIPE_CTRL_PERF_EN
            if (e.pchk) begin
                checks++;
                if (bus.stall_cycles !== e.sc || bus.flush_count !== e.fc) begin
                    errors++;
                    $display("FAIL perf vec%0d: got stall_cycles=%0d flush_count=%0d, expected %0d %0d",
                             e.id, bus.stall_cycles, bus.flush_count, e.sc, e.fc);
                end
            end
`endif
        end
    end
    initial begin
        {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if, bus.branch_flag} = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 4'b1111, 1, 6'b000000, 0, 0);
        step(0, 4'b1001, 0, 6'b011111, 0, 0);
        step(0, 4'b0001, 0, 6'b000011, 0, 0);
        step(0, 4'b0100, 0, 6'b001111, 0, 0);
        step(0, 4'b0010, 0, 6'b000111, 0, 0);
        step(0, 4'b0000, 1, 6'b000000, 1, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        step(0, 4'b0010, 1, 6'b000111, 0, 0);
        step(0, 4'b0010, 0, 6'b000111, 0, 0);
        step(0, 4'b0010, 0, 6'b000111, 0, 0);
        step(0, 4'b0000, 0, 6'b000000, 1, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        step(0, 4'b0001, 1, 6'b000011, 0, 0);
        step(0, 4'b0100, 1, 6'b001111, 0, 0);
        step(0, 4'b0000, 0, 6'b000000, 1, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        step(0, 4'b1000, 1, 6'b011111, 0, 0);
        step(1, 4'b1000, 0, 6'b000000, 0, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        // An idle cycle between two 10-cycle stalls must restart the watchdog.
        for (int k = 0; k < 10; k++) step(0, 4'b0100, 0, 6'b001111, 0, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 4'b0100, 0, 6'b001111, 0, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 4'b0100, 0, 6'b001111, 0, k >= 16);
        for (int k = 0; k < 3; k++) step(0, 4'b0000, 0, 6'b000000, 0, 1);
        step(0, 4'b0000, 1, 6'b000000, 1, 1);
        step(0, 4'b0010, 0, 6'b000111, 0, 1);
        step(1, 4'b1111, 1, 6'b000000, 0, 1);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        for (int k = 0; k < 17; k++) step(0, 4'b0010, 0, 6'b000111, 0, k == 16);
        step(0, 4'b0000, 0, 6'b000000, 0, 1);
        step(1, 4'b0000, 0, 6'b000000, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 4'b0010, 0, 6'b000111, 0, 0);
        step(0, 4'b0000, 1, 6'b000000, 1, 0);
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        step(0, 4'b0000, 1, 6'b000000, 1, 0);
        exp_pchk = 1'b1;
        exp_sc   = 32'd5;
        exp_fc   = 32'd2;
        step(0, 4'b0000, 0, 6'b000000, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d vectors unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
